board_spi_rx: RTL



---
 rtl/board_spi_rx_if.sv | 22 ++
 rtl/board_spi_rx.sv | 114 +++++++++++
 2 files changed

// File: rtl/board_spi_rx_if.sv
// SPI receive-side bundle: raw MCU pins in, committed highlight mask and status out.
interface board_spi_rx_if #(
  parameter int WIDTH = 64
);
  logic             sck;
  logic             sdi;
  logic             load;
  logic [WIDTH-1:0] mask;
  logic             mask_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output sck, sdi, load,
    input  mask, mask_valid, frame_err, busy
  );

  modport slave (
    input  sck, sdi, load,
    output mask, mask_valid, frame_err, busy
  );
endinterface

// File: rtl/board_spi_rx.sv
// Oversampled SPI slave that commits a WIDTH-bit square-highlight mask atomically per exact-length frame.
// mask/mask_valid follow the raw load fall by SYNC_STAGES+2 clk; no backpressure, the MCU paces frames.
module board_spi_rx #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset,
  board_spi_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] SETTLE   = CW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, RECV} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
  logic                   s_sck_d, s_load_d;
  logic                   s_sck, s_sdi, s_load;
  logic                   sck_rise, load_rise, load_fall;

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_ok, done_bad;
  logic [WIDTH-1:0] mask_q;
  logic             mask_valid_q, frame_err_q;

  logic settle_en, start, shift_en, fin_ok, fin_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      s_sck_d   <= 1'b0;
      s_load_d  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.sdi};
      load_sync <= {load_sync[SYNC_STAGES-2:0], bus.load};
      s_sck_d   <= s_sck;
      s_load_d  <= s_load;
    end
  end

  assign s_sck     = sck_sync[SYNC_STAGES-1];
  assign s_sdi     = sdi_sync[SYNC_STAGES-1];
  assign s_load    = load_sync[SYNC_STAGES-1];
  assign sck_rise  = s_sck & ~s_sck_d;
  assign load_rise = s_load & ~s_load_d;
  assign load_fall = ~s_load & s_load_d;

  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT_LOW;
    else        state <= state_nxt;
  end

  // The synchronizers reset to 0, so WAIT_LOW must let them fill before trusting
  // s_load; otherwise a load held high through reset would look like a fresh rise.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOW: if (cnt == SETTLE && !s_load && !s_load_d) state_nxt = IDLE;
      IDLE:     if (load_rise) state_nxt = RECV;
      RECV:     if (load_fall) state_nxt = IDLE;
      default:  state_nxt = WAIT_LOW;
    endcase
  end

  always_comb begin
    settle_en = (state == WAIT_LOW) && (cnt != SETTLE);
    start     = (state == IDLE) && load_rise;
    shift_en  = (state == RECV) && sck_rise && s_load;
    fin_ok    = (state == RECV) && load_fall && (cnt == CNT_FULL);
    fin_bad   = (state == RECV) && load_fall && (cnt != CNT_FULL);
  end

  // shreg is read one cycle after the frame closes; the earliest next start
  // clears it on that same edge, so the commit always sees the finished frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg        <= '0;
      cnt          <= '0;
      done_ok      <= 1'b0;
      done_bad     <= 1'b0;
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      done_ok      <= fin_ok;
      done_bad     <= fin_bad;
      mask_valid_q <= done_ok;
      frame_err_q  <= done_bad;
      if (done_ok) mask_q <= shreg;
      if (start) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[WIDTH-2:0], s_sdi};
        if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
      end else if (settle_en) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.mask       = mask_q;
  assign bus.mask_valid = mask_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state == RECV);
endmodule
